lsu_issue_queue: RTL and testbench
==================================

Name: lsu_issue_queue

Overview:
- In-order memory reservation station directly upstream of the load-store unit.
- Holds dispatched load/store instructions and captures missing rs1/rs2 operands from the common data bus (CDB) by ROB tag.
- Issues the oldest entry to the LSU once its operands are ready and the LSU is not busy.
- Memory ops leave in program order; no load/store reordering happens here.

Parameters:
DEPTH, 4, number of queue entries (power of two)
ADDR_LEN, 2, log2(DEPTH); pointer width
TAG_LEN, 4, ROB tag width

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
flush_i  input  1  squash all entries (mispredict recovery)
dispatch_valid_i  input  1  dispatch presents a memory op this cycle
dispatch_ready_o  output  1  queue accepts a dispatch this cycle (= !full_o)
dispatch_pc_i  input  32  instruction PC
dispatch_inst_i  input  32  raw instruction word
dispatch_rob_tag_i  input  TAG_LEN  ROB tag of the instruction
dispatch_rs1_ready_i  input  1  rs1 value valid at dispatch
dispatch_rs1_value_i  input  32  rs1 value (meaningful if ready)
dispatch_rs1_tag_i  input  TAG_LEN  producer tag of rs1 (meaningful if not ready)
dispatch_rs2_ready_i  input  1  rs2 value valid at dispatch
dispatch_rs2_value_i  input  32  rs2 value
dispatch_rs2_tag_i  input  TAG_LEN  producer tag of rs2
cdb_valid_i  input  1  CDB broadcast valid
cdb_tag_i  input  TAG_LEN  broadcasting ROB tag
cdb_value_i  input  32  broadcast result
lsu_busy_i  input  1  LSU load/store buffer full; no issue allowed
lsu_request_o  output  1  one-cycle issue pulse to LSU
lsu_pc_o  output  32  issued PC
lsu_inst_o  output  32  issued instruction
lsu_rs1_value_o  output  32  issued rs1 value
lsu_rs2_value_o  output  32  issued rs2 value
lsu_rob_tag_o  output  TAG_LEN  issued ROB tag
full_o  output  1  count == DEPTH
empty_o  output  1  count == 0

Behaviour:
- Storage: circular buffer with head/tail pointers of ADDR_LEN bits that wrap modulo DEPTH; count is ADDR_LEN+1 bits.
- Per-entry fields: valid, pc, inst, rob_tag, rs1/rs2 ready, value, tag.
- Reset (reset_i=1 at edge):
  - clears valid bits, pointers and count;
  - lsu_request_o=0 and all lsu_*_o=0;
  - full_o=0, empty_o=1, dispatch_ready_o=1.
- Flush (flush_i=1, no reset):
  - same clearing as reset, except lsu_*_o data may hold stale values; lsu_request_o=0 next cycle;
  - a dispatch in the same cycle is dropped;
  - a CDB broadcast in the same cycle has no effect.
- Enqueue: on an edge with dispatch_valid_i & dispatch_ready_o, write the entry at tail and advance tail.
  - dispatch_ready_o comes from the pre-edge count, so a full queue refuses dispatch even if an issue frees a slot that same edge.
  - Loads: if opcode == OP_LOAD, store rs2 ready=1 regardless of input; rs2 value is don't-care.
- CDB capture: on each edge with cdb_valid_i, every valid entry whose rsX is not ready and whose rsX tag == cdb_tag_i sets ready=1 and value=cdb_value_i.
  - The entry being enqueued on that same edge is also compared; it is stored ready with the CDB value.
- Issue condition (combinational, pre-edge): !empty & head rs1 ready & head rs2 ready & !lsu_busy_i.
  - Readiness is pre-edge only: an operand captured from the CDB on edge k makes the head eligible for the decision made at edge k+1. There is no same-cycle CDB bypass to issue.
- Issue action at the edge:
  - register head fields onto lsu_*_o;
  - set lsu_request_o=1 for exactly one cycle;
  - clear the head valid bit and advance head.
  - Without an issue, lsu_request_o=0 next cycle and lsu_*_o hold their values.
- Latency: a fully-ready op dispatched at edge k with LSU idle gets lsu_request_o high during the cycle after edge k+1. Sustained throughput is 1 issue/cycle.
- Count: +1 on enqueue only, −1 on issue only, unchanged on both or neither. full_o and empty_o are derived from the registered count.
- lsu_busy_i high: the head is held indefinitely and CDB capture continues for all entries.
- Non-head entries never issue even if ready (strict in-order issue).

Test Plan:
- Reset, then dispatch an LW with rs1 ready (value 0x100), LSU idle → lsu_request_o=1 for exactly one cycle two edges after dispatch; lsu_rs1_value_o=0x100; empty_o=1 afterwards.
- Dispatch an SW with rs1 ready and rs2 waiting on tag 5; broadcast CDB tag 5, value 0xDEADBEEF, three cycles later → issue one cycle after the broadcast edge with lsu_rs2_value_o=0xDEADBEEF.
- Dispatch an LW waiting on tag 3 while CDB broadcasts tag 3 (value 0x40) in the same cycle → entry is captured ready; issues next edge with rs1=0x40.
- Fill 4 entries with lsu_busy_i=1 → full_o=1, dispatch_ready_o=0, a 5th dispatch is dropped. Release busy → 4 issues on consecutive cycles in dispatch order, with tags in order; pointers wrap correctly on a refill.
- Head waits on tag 2 while the second entry is ready → no issue until tag 2 broadcasts; then head issues first and the second entry the cycle after.
- With 3 entries queued, assert flush_i concurrently with a dispatch and a CDB broadcast → next cycle empty_o=1, count 0, lsu_request_o=0; a later dispatch is accepted normally.

Source files
------------

// File: rtl/lsu_issue_queue.sv
// In-order memory reservation station feeding the load-store unit.
// Captures missing operands from the CDB by ROB tag and issues only the oldest entry.
module lsu_issue_queue #(
   parameter int DEPTH    = 4,
   parameter int ADDR_LEN = 2,
   parameter int TAG_LEN  = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               flush_i,
   input  logic               dispatch_valid_i,
   output logic               dispatch_ready_o,
   input  logic [31:0]        dispatch_pc_i,
   input  logic [31:0]        dispatch_inst_i,
   input  logic [TAG_LEN-1:0] dispatch_rob_tag_i,
   input  logic               dispatch_rs1_ready_i,
   input  logic [31:0]        dispatch_rs1_value_i,
   input  logic [TAG_LEN-1:0] dispatch_rs1_tag_i,
   input  logic               dispatch_rs2_ready_i,
   input  logic [31:0]        dispatch_rs2_value_i,
   input  logic [TAG_LEN-1:0] dispatch_rs2_tag_i,
   input  logic               cdb_valid_i,
   input  logic [TAG_LEN-1:0] cdb_tag_i,
   input  logic [31:0]        cdb_value_i,
   input  logic               lsu_busy_i,
   output logic               lsu_request_o,
   output logic [31:0]        lsu_pc_o,
   output logic [31:0]        lsu_inst_o,
   output logic [31:0]        lsu_rs1_value_o,
   output logic [31:0]        lsu_rs2_value_o,
   output logic [TAG_LEN-1:0] lsu_rob_tag_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam logic [6:0]          OP_LOAD  = 7'b0000011;
   localparam logic [ADDR_LEN:0]   FULL_CNT = (ADDR_LEN+1)'(DEPTH);

   logic               valid_q    [DEPTH];
   logic [31:0]        pc_q       [DEPTH];
   logic [31:0]        inst_q     [DEPTH];
   logic [TAG_LEN-1:0] rob_tag_q  [DEPTH];
   logic               rs1_rdy_q  [DEPTH];
   logic [31:0]        rs1_val_q  [DEPTH];
   logic [TAG_LEN-1:0] rs1_tag_q  [DEPTH];
   logic               rs2_rdy_q  [DEPTH];
   logic [31:0]        rs2_val_q  [DEPTH];
   logic [TAG_LEN-1:0] rs2_tag_q  [DEPTH];

   logic [ADDR_LEN-1:0] head_q, head_d, tail_q, tail_d;
   logic [ADDR_LEN:0]   count_q, count_d;
   logic                enq, issue, enq_is_load;
   logic                rs1_hit, rs2_hit, enq_rs1_rdy, enq_rs2_rdy;
   logic [31:0]         enq_rs1_val, enq_rs2_val;

   assign full_o           = (count_q == FULL_CNT);
   assign empty_o          = (count_q == '0);
   assign dispatch_ready_o = ~full_o;

   always_comb begin
      enq         = dispatch_valid_i & ~full_o;
      issue       = ~empty_o & rs1_rdy_q[head_q] & rs2_rdy_q[head_q] & ~lsu_busy_i;
      head_d      = head_q + ADDR_LEN'(issue);
      tail_d      = tail_q + ADDR_LEN'(enq);
      count_d     = count_q;
      if (enq && !issue)
         count_d = count_q + 1'b1;
      else if (issue && !enq)
         count_d = count_q - 1'b1;
      // The entry being written this edge also snoops the CDB; loads never wait on rs2.
      enq_is_load = (dispatch_inst_i[6:0] == OP_LOAD);
      rs1_hit     = cdb_valid_i & ~dispatch_rs1_ready_i & (dispatch_rs1_tag_i == cdb_tag_i);
      rs2_hit     = cdb_valid_i & ~dispatch_rs2_ready_i & ~enq_is_load &
                    (dispatch_rs2_tag_i == cdb_tag_i);
      enq_rs1_rdy = dispatch_rs1_ready_i | rs1_hit;
      enq_rs2_rdy = dispatch_rs2_ready_i | enq_is_load | rs2_hit;
      enq_rs1_val = rs1_hit ? cdb_value_i : dispatch_rs1_value_i;
      enq_rs2_val = rs2_hit ? cdb_value_i : dispatch_rs2_value_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
         head_q          <= '0;
         tail_q          <= '0;
         count_q         <= '0;
         lsu_request_o   <= 1'b0;
         lsu_pc_o        <= '0;
         lsu_inst_o      <= '0;
         lsu_rs1_value_o <= '0;
         lsu_rs2_value_o <= '0;
         lsu_rob_tag_o   <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         lsu_request_o <= 1'b0;
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         lsu_request_o <= issue;
         if (issue) begin
            lsu_pc_o        <= pc_q[head_q];
            lsu_inst_o      <= inst_q[head_q];
            lsu_rs1_value_o <= rs1_val_q[head_q];
            lsu_rs2_value_o <= rs2_val_q[head_q];
            lsu_rob_tag_o   <= rob_tag_q[head_q];
            valid_q[head_q] <= 1'b0;
         end
         if (enq) valid_q[tail_q] <= 1'b1;
      end
   end

   // Entry payload carries no reset; validity alone decides what is live.
   always_ff @(posedge clk_i) begin
      if (cdb_valid_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !rs1_rdy_q[i] && rs1_tag_q[i] == cdb_tag_i) begin
               rs1_rdy_q[i] <= 1'b1;
               rs1_val_q[i] <= cdb_value_i;
            end
            if (valid_q[i] && !rs2_rdy_q[i] && rs2_tag_q[i] == cdb_tag_i) begin
               rs2_rdy_q[i] <= 1'b1;
               rs2_val_q[i] <= cdb_value_i;
            end
         end
      end
      if (enq) begin
         pc_q[tail_q]      <= dispatch_pc_i;
         inst_q[tail_q]    <= dispatch_inst_i;
         rob_tag_q[tail_q] <= dispatch_rob_tag_i;
         rs1_rdy_q[tail_q] <= enq_rs1_rdy;
         rs1_val_q[tail_q] <= enq_rs1_val;
         rs1_tag_q[tail_q] <= dispatch_rs1_tag_i;
         rs2_rdy_q[tail_q] <= enq_rs2_rdy;
         rs2_val_q[tail_q] <= enq_rs2_val;
         rs2_tag_q[tail_q] <= dispatch_rs2_tag_i;
      end
   end

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Directed bench for lsu_issue_queue: hand-computed expectations for issue order,
// CDB capture, full/empty flags, flush and reset.
module tb_lsu_issue_queue;

   logic        clk_i = 1'b0;
   logic        reset_i, flush_i, dispatch_valid_i, dispatch_ready_o;
   logic [31:0] dispatch_pc_i, dispatch_inst_i;
   logic [3:0]  dispatch_rob_tag_i;
   logic        dispatch_rs1_ready_i, dispatch_rs2_ready_i;
   logic [31:0] dispatch_rs1_value_i, dispatch_rs2_value_i;
   logic [3:0]  dispatch_rs1_tag_i, dispatch_rs2_tag_i;
   logic        cdb_valid_i;
   logic [3:0]  cdb_tag_i;
   logic [31:0] cdb_value_i;
   logic        lsu_busy_i, lsu_request_o;
   logic [31:0] lsu_pc_o, lsu_inst_o, lsu_rs1_value_o, lsu_rs2_value_o;
   logic [3:0]  lsu_rob_tag_o;
   logic        full_o, empty_o;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [31:0] LW = 32'h0000_2003;
   localparam logic [31:0] SW = 32'h0020_2023;

   lsu_issue_queue #(.DEPTH(4), .ADDR_LEN(2), .TAG_LEN(4)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
      .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
      .dispatch_pc_i(dispatch_pc_i), .dispatch_inst_i(dispatch_inst_i),
      .dispatch_rob_tag_i(dispatch_rob_tag_i),
      .dispatch_rs1_ready_i(dispatch_rs1_ready_i), .dispatch_rs1_value_i(dispatch_rs1_value_i),
      .dispatch_rs1_tag_i(dispatch_rs1_tag_i),
      .dispatch_rs2_ready_i(dispatch_rs2_ready_i), .dispatch_rs2_value_i(dispatch_rs2_value_i),
      .dispatch_rs2_tag_i(dispatch_rs2_tag_i),
      .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_value_i(cdb_value_i),
      .lsu_busy_i(lsu_busy_i), .lsu_request_o(lsu_request_o),
      .lsu_pc_o(lsu_pc_o), .lsu_inst_o(lsu_inst_o),
      .lsu_rs1_value_o(lsu_rs1_value_o), .lsu_rs2_value_o(lsu_rs2_value_o),
      .lsu_rob_tag_o(lsu_rob_tag_o), .full_o(full_o), .empty_o(empty_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic disp(input logic [31:0] pc, input logic [31:0] inst, input logic [3:0] tag,
                       input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                       input logic r2, input logic [31:0] v2, input logic [3:0] t2);
      dispatch_valid_i     = 1'b1;
      dispatch_pc_i        = pc;
      dispatch_inst_i      = inst;
      dispatch_rob_tag_i   = tag;
      dispatch_rs1_ready_i = r1;
      dispatch_rs1_value_i = v1;
      dispatch_rs1_tag_i   = t1;
      dispatch_rs2_ready_i = r2;
      dispatch_rs2_value_i = v2;
      dispatch_rs2_tag_i   = t2;
   endtask

   task automatic cdb(input logic v, input logic [3:0] tag, input logic [31:0] val);
      cdb_valid_i = v;
      cdb_tag_i   = tag;
      cdb_value_i = val;
   endtask

   initial begin
      reset_i = 1'b1; flush_i = 1'b0; lsu_busy_i = 1'b0;
      dispatch_valid_i = 1'b0;
      disp(32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
      dispatch_valid_i = 1'b0;
      cdb(1'b0, 4'h0, 32'h0);
      step(); step();
      reset_i = 1'b0;
      check("rst_empty", empty_o, 1);
      check("rst_full", full_o, 0);
      check("rst_ready", dispatch_ready_o, 1);
      check("rst_req", lsu_request_o, 0);
      check("rst_pc", lsu_pc_o, 0);

      // LW with rs1 ready; rs2 not ready but loads ignore it
      disp(32'h1000, LW, 4'd1, 1'b1, 32'h100, 4'd0, 1'b0, 32'h0, 4'd0);
      step();
      dispatch_valid_i = 1'b0;
      check("t1_req_early", lsu_request_o, 0);
      check("t1_nonempty", empty_o, 0);
      step();
      check("t1_req", lsu_request_o, 1);
      check("t1_rs1", lsu_rs1_value_o, 32'h100);
      check("t1_pc", lsu_pc_o, 32'h1000);
      check("t1_tag", lsu_rob_tag_o, 1);
      check("t1_inst", lsu_inst_o, LW);
      check("t1_empty", empty_o, 1);
      step();
      check("t1_req_pulse", lsu_request_o, 0);

      // SW waiting on tag 5; a tag 6 broadcast must not wake it
      disp(32'h2000, SW, 4'd2, 1'b1, 32'h200, 4'd0, 1'b0, 32'h1234, 4'd5);
      step();
      dispatch_valid_i = 1'b0;
      cdb(1'b1, 4'd6, 32'h6666);
      step();
      cdb(1'b0, 4'd0, 32'h0);
      check("t2_wait1", lsu_request_o, 0);
      step();
      check("t2_wait2", lsu_request_o, 0);
      cdb(1'b1, 4'd5, 32'hDEADBEEF);
      step();
      cdb(1'b0, 4'd0, 32'h0);
      check("t2_no_bypass", lsu_request_o, 0);
      step();
      check("t2_req", lsu_request_o, 1);
      check("t2_rs2", lsu_rs2_value_o, 32'hDEADBEEF);
      check("t2_rs1", lsu_rs1_value_o, 32'h200);
      check("t2_tag", lsu_rob_tag_o, 2);

      // capture on the dispatch edge itself
      disp(32'h3000, LW, 4'd3, 1'b0, 32'h0, 4'd3, 1'b0, 32'h0, 4'd0);
      cdb(1'b1, 4'd3, 32'h40);
      step();
      dispatch_valid_i = 1'b0;
      cdb(1'b0, 4'd0, 32'h0);
      check("t3_req_early", lsu_request_o, 0);
      step();
      check("t3_req", lsu_request_o, 1);
      check("t3_rs1", lsu_rs1_value_o, 32'h40);
      check("t3_tag", lsu_rob_tag_o, 3);
      step();

      // fill with LSU busy, drop extra dispatches, then drain in order
      lsu_busy_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         disp(32'h4000 + 32'(i), SW, 4'(8 + i), 1'b1, 32'(i), 4'd0, 1'b1, 32'(16 + i), 4'd0);
         step();
      end
      check("t4_full", full_o, 1);
      check("t4_ready", dispatch_ready_o, 0);
      check("t4_req_busy", lsu_request_o, 0);
      disp(32'h4100, SW, 4'd12, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0);
      step();
      check("t4_still_full", full_o, 1);
      disp(32'h4200, SW, 4'd13, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0);
      lsu_busy_i = 1'b0;
      step();
      dispatch_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t4_req", lsu_request_o, 1);
         check("t4_tag", lsu_rob_tag_o, 32'(8 + i));
         check("t4_rs2", lsu_rs2_value_o, 32'(16 + i));
         if (i < 3) step();
      end
      check("t4_empty", empty_o, 1);
      step();
      check("t4_drained", lsu_request_o, 0);
      // refill across the wrapped pointers, back-to-back
      disp(32'h5000, LW, 4'd14, 1'b1, 32'h14, 4'd0, 1'b0, 32'h0, 4'd0);
      step();
      disp(32'h5004, LW, 4'd15, 1'b1, 32'h15, 4'd0, 1'b0, 32'h0, 4'd0);
      step();
      dispatch_valid_i = 1'b0;
      check("t4_wrap_req0", lsu_request_o, 1);
      check("t4_wrap_tag0", lsu_rob_tag_o, 14);
      step();
      check("t4_wrap_req1", lsu_request_o, 1);
      check("t4_wrap_tag1", lsu_rob_tag_o, 15);
      step();
      check("t4_wrap_idle", lsu_request_o, 0);

      // blocked head holds back a ready younger entry
      disp(32'h6000, LW, 4'd4, 1'b0, 32'h0, 4'd2, 1'b0, 32'h0, 4'd0);
      step();
      disp(32'h6004, LW, 4'd6, 1'b1, 32'h66, 4'd0, 1'b0, 32'h0, 4'd0);
      step();
      dispatch_valid_i = 1'b0;
      cdb(1'b1, 4'd7, 32'h7777);
      step();
      cdb(1'b0, 4'd0, 32'h0);
      check("t5_hold0", lsu_request_o, 0);
      step();
      check("t5_hold1", lsu_request_o, 0);
      cdb(1'b1, 4'd2, 32'h77);
      step();
      cdb(1'b0, 4'd0, 32'h0);
      check("t5_hold2", lsu_request_o, 0);
      step();
      check("t5_req_head", lsu_request_o, 1);
      check("t5_tag_head", lsu_rob_tag_o, 4);
      check("t5_rs1_head", lsu_rs1_value_o, 32'h77);
      step();
      check("t5_req_next", lsu_request_o, 1);
      check("t5_tag_next", lsu_rob_tag_o, 6);
      step();
      check("t5_idle", lsu_request_o, 0);

      // flush with 3 queued, concurrent dispatch and CDB
      lsu_busy_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         disp(32'h7000 + 32'(i), LW, 4'(1 + i), 1'b1, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
         step();
      end
      check("t6_nonempty", empty_o, 0);
      lsu_busy_i = 1'b0;
      flush_i    = 1'b1;
      disp(32'h7100, LW, 4'd5, 1'b1, 32'h0, 4'd0, 1'b0, 32'h0, 4'd0);
      cdb(1'b1, 4'd9, 32'h99);
      step();
      flush_i = 1'b0;
      dispatch_valid_i = 1'b0;
      cdb(1'b0, 4'd0, 32'h0);
      check("t6_empty", empty_o, 1);
      check("t6_full", full_o, 0);
      check("t6_req", lsu_request_o, 0);
      step();
      check("t6_req_after", lsu_request_o, 0);
      disp(32'h8000, LW, 4'd9, 1'b1, 32'h88, 4'd0, 1'b0, 32'h0, 4'd0);
      step();
      dispatch_valid_i = 1'b0;
      step();
      check("t6_post_req", lsu_request_o, 1);
      check("t6_post_tag", lsu_rob_tag_o, 9);
      check("t6_post_pc", lsu_pc_o, 32'h8000);
      step();
      check("t6_post_empty", empty_o, 1);

      // reset clears the issue outputs
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      check("rst2_pc", lsu_pc_o, 0);
      check("rst2_rs1", lsu_rs1_value_o, 0);
      check("rst2_tag", lsu_rob_tag_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
